// File: rtl/contador_sincrono_decrescente.sv
// rtl/contador_sincrono_decrescente.sv - synchronous N-bit down counter with load, enable, modulus and borrow
module contador_sincrono_decrescente #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         CK,
    input  logic         CLR,
    input  logic         LD,
    input  logic [N-1:0] D,
    input  logic         EN,
    output logic [N-1:0] Q,
    output logic         ZERO,
    output logic         BO
);

    // Highest legal count; with MOD == 2^N this is all-ones.
    localparam logic [N-1:0] MAX_V = N'(MOD - 1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         q_is_zero;

    assign q_is_zero = (q_q == '0);

    // Next count: clear beats load, load beats count, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (LD) begin
            // Out-of-range loads saturate so the register never holds an illegal value.
            q_d = (D > MAX_V) ? MAX_V : D;
        end else if (EN) begin
            // Values above MAX_V (only possible through corruption) fall through
            // the plain decrement and walk back into range.
            q_d = q_is_zero ? MAX_V : (q_q - 1'b1);
        end
    end

    // Single state register with synchronous active-high clear.
    always_ff @(posedge CK) begin
        if (CLR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign ZERO = q_is_zero;
    // Borrow feeds the next stage's EN so it decrements on our wrap edge.
    assign BO   = EN & q_is_zero;

endmodule

// File: tb/tb_contador_sincrono_decrescente.sv
// tb/tb_contador_sincrono_decrescente.sv - scoreboard bench for contador_sincrono_decrescente
module tb_contador_sincrono_decrescente;

    logic       ck = 1'b0;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic       en = 1'b0;
    logic [3:0] d = '0;

    logic [3:0] q16, q10, qlo, qhi;
    logic       z16, b16, z10, b10, zlo, blo, zhi, bhi;

    always #5 ck = ~ck;

    contador_sincrono_decrescente #(.N(4), .MOD(16)) u_d16 (
        .CK(ck), .CLR(clr), .LD(ld), .D(d), .EN(en), .Q(q16), .ZERO(z16), .BO(b16));

    contador_sincrono_decrescente #(.N(4), .MOD(10)) u_d10 (
        .CK(ck), .CLR(clr), .LD(ld), .D(d), .EN(en), .Q(q10), .ZERO(z10), .BO(b10));

    contador_sincrono_decrescente #(.N(4), .MOD(16)) u_lo (
        .CK(ck), .CLR(clr), .LD(1'b0), .D(4'd0), .EN(en), .Q(qlo), .ZERO(zlo), .BO(blo));

    contador_sincrono_decrescente #(.N(4), .MOD(16)) u_hi (
        .CK(ck), .CLR(clr), .LD(1'b0), .D(4'd0), .EN(blo), .Q(qhi), .ZERO(zhi), .BO(bhi));

    typedef struct {
        bit          chk_q;
        logic [31:0] q16;
        logic [31:0] q10;
        logic [31:0] v8;
        logic        en;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain modular arithmetic on integers.
    int  m16 = 0;
    int  m10 = 0;
    int  m8  = 0;
    bit  have_state = 1'b0;
    bit  stim_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be during it,
    // then advance the model across the rising edge.
    task automatic step(input bit c, input bit l, input int dv, input bit e);
        exp_t x;
        @(negedge ck);
        clr = c;
        ld  = l;
        d   = 4'(dv);
        en  = e;
        x.chk_q = have_state;
        x.q16   = m16;
        x.q10   = m10;
        x.v8    = m8;
        x.en    = e;
        exp_q.push_back(x);
        @(posedge ck);
        if (c) begin
            m16 = 0; m10 = 0; m8 = 0;
        end else begin
            if (l) begin
                m16 = (dv > 15) ? 15 : dv;
                m10 = (dv > 9) ? 9 : dv;
            end else if (e) begin
                m16 = (m16 + 15) % 16;
                m10 = (m10 + 9) % 10;
            end
            if (e) m8 = (m8 + 255) % 256;
        end
        if (c) have_state = 1'b1;
    endtask

    // Monitor: every cycle the counters present an output; compare it to the
    // oldest outstanding expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge ck);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                if (x.chk_q) begin
                    check("q_mod16",  32'(q16), x.q16);
                    check("zero_mod16", 32'(z16), 32'(x.q16 == 0));
                    check("bo_mod16", 32'(b16), 32'(x.en && x.q16 == 0));
                    check("q_mod10",  32'(q10), x.q10);
                    check("zero_mod10", 32'(z10), 32'(x.q10 == 0));
                    check("bo_mod10", 32'(b10), 32'(x.en && x.q10 == 0));
                    check("cascade_value", 32'({qhi, qlo}), x.v8);
                    check("cascade_bo", 32'(bhi), 32'(x.en && x.v8 == 0));
                end
            end
        end
    end

    initial begin
        // Reset with load and enable also asserted; clear must win.
        step(1, 1, 7, 1);
        // Full wrap: 0,15,14,...,0,15 with borrow only at 0; also cascade 255 then 239.
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1);
        // Load and hold.
        step(0, 1, 9, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        // Out-of-range load: saturates to MOD-1 on the MOD=10 counter.
        step(0, 1, 13, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        // Load beats count on the same edge.
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        // Mid-count clear beats a simultaneous load.
        step(0, 1, 12, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        step(1, 1, 3, 1);
        step(0, 0, 0, 1);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 10),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 75));
        end
        step(0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(posedge ck);
            budget++;
        end
        @(negedge ck);
        #3;
        n_checks++;
        if (!stim_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 (stimulus done %0d)", exp_q.size(), stim_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
